alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: in_valid  input  1  the ALU result on S/CLFZN/dest is presented this cycle.
REQ-005 Port: in_ready  output  1  the block accepts a result this cycle.
REQ-006 Port: S  input  16  ALU result.
REQ-007 Port: CLFZN  input  5  ALU flags: [4]=C, [3]=L, [2]=F, [1]=Z, [0]=N.
REQ-008 Port: dest  input  4  destination register index.
REQ-009 Port: reg_we  input  1  the instruction writes S to dest.
REQ-010 Port: flag_we  input  1  the instruction updates the processor status register.
REQ-011 Port: wb_valid  output  1  a register-file write is pending at the FIFO head.
REQ-012 Port: wb_ready  input  1  the register file consumes the head this cycle.
REQ-013 Port: wb_data  output  16  head write data.
REQ-014 Port: wb_addr  output  4  head write register index.
REQ-015 Port: psr  output  5  processor status register, same bit order as CLFZN.
REQ-016 Port: carry  output  1  psr[4], fed back to the ALU carry input.
REQ-017 Port: wb_count  output  16  number of register writes retired.

Function
REQ-018 Accept = in_valid && in_ready; Retire = wb_valid && wb_ready.
REQ-019 A 2-entry FIFO of {dest, S} SHALL buffer writes; occupancy count is 0..2.
REQ-020 in_ready SHALL be 1 when count < 2 and 0 when count = 2, regardless of reg_we, with no combinational path from wb_ready.
REQ-021 On Accept with reg_we=1 the block SHALL push {dest, S}; with reg_we=0 it SHALL push nothing.
REQ-022 wb_valid SHALL equal (count != 0); wb_data/wb_addr SHALL show the oldest entry and SHALL hold stable while wb_valid=1 and wb_ready=0.
REQ-023 When wb_valid=0, wb_data and wb_addr SHALL be 0.
REQ-024 On push and Retire in the same cycle, count SHALL be unchanged and the order SHALL be preserved.
REQ-025 Push at count 2 is impossible because in_ready=0; Retire at count 0 is impossible because wb_valid=0.
REQ-026 Entries SHALL retire in acceptance order; the write pointer and read pointer SHALL each wrap modulo 2.
REQ-027 On Accept with flag_we=1, psr SHALL be loaded with CLFZN at that edge, so carry is valid for the next cycle's ALU operation; otherwise psr SHALL hold.
REQ-028 A psr update SHALL NOT wait for the write to drain from the FIFO.
REQ-029 wb_count SHALL increment by 1 on each Retire and SHALL wrap from 0xFFFF to 0x0000.
REQ-030 Accepts with in_ready=0 SHALL NOT occur; S, CLFZN, dest and the enables are ignored while in_ready=0 or in_valid=0.
REQ-031 All outputs SHALL be registered, or derived only from registered state; there is no combinational input-to-output path.

Reset
REQ-032 When reset=1 at an edge, the following SHALL be cleared: count=0, both pointers=0, psr=0, wb_count=0, FIFO contents=0.
REQ-033 During reset, wb_valid=0 and in_ready=1 from the next cycle; carry=0.
REQ-034 A reset asserted mid-operation SHALL discard all pending writes without retiring them, and wb_count SHALL NOT increment in that cycle.
REQ-035 Reset SHALL take priority over a simultaneous Accept or Retire.

Verification
REQ-036 Reset, then Accept S=0x1234, dest=3, reg_we=1, flag_we=1, CLFZN=0b10010, with wb_ready=1. Required response: the next cycle shows wb_valid=1, wb_addr=3, wb_data=0x1234, psr=0b10010, carry=1; the following cycle shows wb_count=1 and wb_valid=0.
REQ-037 Hold wb_ready=0 and Accept three back-to-back writes (0xA, 0xB, 0xC). Required response: 0xA and 0xB are accepted, and in_ready=0 with 0xC held; after wb_ready=1, writes retire as 0xA, 0xB, 0xC in order.
REQ-038 At count=1, push and Retire in the same cycle. Required response: count stays 1, and the head changes to the new entry.
REQ-039 Accept reg_we=0, flag_we=1, CLFZN=0b00001. Required response: psr=0b00001, no FIFO push, wb_count unchanged. Then accept reg_we=1, flag_we=0. Required response: psr is held.
REQ-040 Preload wb_count to 0xFFFF by 65535 retires, then retire one more. Required response: wb_count=0x0000.
REQ-041 With 2 entries pending, assert reset for 1 cycle. Required response: wb_valid=0, psr=0, wb_count=0, in_ready=1, and no stale entry appears afterward.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers register-file writes in a 2-entry FIFO and
// keeps the processor status register up to date.
// The PSR is loaded at accept time so the carry feedback is valid for the
// very next ALU operation, independent of how long the write takes to drain.
module alu_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] S,
    input  logic [4:0]  CLFZN,
    input  logic [3:0]  dest,
    input  logic        reg_we,
    input  logic        flag_we,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_addr,
    output logic [4:0]  psr,
    output logic        carry,
    output logic [15:0] wb_count
);

    localparam int DEPTH = 2;

    // FIFO state
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [15:0] data_q [DEPTH];
    logic [15:0] data_d [DEPTH];
    logic [3:0]  addr_q [DEPTH];
    logic [3:0]  addr_d [DEPTH];

    // Status and retire counter
    logic [4:0]  psr_q, psr_d;
    logic [15:0] wb_count_q, wb_count_d;

    logic accept;
    logic retire;
    logic push;

    // Handshake decode; in_ready depends only on registered occupancy
    always_comb begin
        in_ready = (count_q != 2'd2);
        wb_valid = (count_q != 2'd0);
        accept   = in_valid && in_ready;
        retire   = wb_valid && wb_ready;
        push     = accept && reg_we;
    end

    // Head presentation; zeroed when nothing is pending
    always_comb begin
        wb_data  = wb_valid ? data_q[rd_ptr_q] : 16'h0000;
        wb_addr  = wb_valid ? addr_q[rd_ptr_q] : 4'h0;
        psr      = psr_q;
        carry    = psr_q[4];
        wb_count = wb_count_q;
    end

    // Pointer, occupancy, status and counter next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        psr_d      = psr_q;
        wb_count_d = wb_count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (retire) begin
            rd_ptr_d   = ~rd_ptr_q;
            wb_count_d = wb_count_q + 16'd1;
        end
        case ({push, retire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (accept && flag_we) begin
            psr_d = CLFZN;
        end
    end

    // Control registers; reset overrides any simultaneous accept or retire
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            psr_q      <= 5'd0;
            wb_count_q <= 16'd0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            psr_q      <= psr_d;
            wb_count_q <= wb_count_d;
        end
    end

    // One storage slot per FIFO entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Load this slot when the write pointer selects it
            always_comb begin
                data_d[gi] = data_q[gi];
                addr_d[gi] = addr_q[gi];
                if (push && (wr_ptr_q == 1'(gi))) begin
                    data_d[gi] = S;
                    addr_d[gi] = dest;
                end
            end

            // Slot storage, cleared on reset so nothing stale survives
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q[gi] <= 16'h0000;
                    addr_q[gi] <= 4'h0;
                end else begin
                    data_q[gi] <= data_d[gi];
                    addr_q[gi] <= addr_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a random
// run checked against a queue-based model of the writeback stage.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S;
    logic [4:0]  CLFZN;
    logic [3:0]  dest;
    logic        reg_we;
    logic        flag_we;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [3:0]  wb_addr;
    logic [4:0]  psr;
    logic        carry;
    logic [15:0] wb_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: pending writes in order, status register, retire counter
    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;
    ent_t        mq[$];
    logic [4:0]  m_psr = 5'd0;
    logic [15:0] m_cnt = 16'd0;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .S        (S),
        .CLFZN    (CLFZN),
        .dest     (dest),
        .reg_we   (reg_we),
        .flag_we  (flag_we),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_addr  (wb_addr),
        .psr      (psr),
        .carry    (carry),
        .wb_count (wb_count)
    );

    // Advance one clock edge and apply the same edge to the model
    task automatic tick();
        bit acc;
        bit ret;
        acc = in_valid && (mq.size() < 2);
        ret = wb_ready && (mq.size() > 0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_psr = 5'd0;
            m_cnt = 16'd0;
        end else begin
            if (ret) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (acc && reg_we) mq.push_back({dest, S});
            if (acc && flag_we) m_psr = CLFZN;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; reg_we = 0; flag_we = 0; wb_ready = 0;
        S = '0; CLFZN = '0; dest = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        tests_run++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_hs: wb_valid=%0b in_ready=%0b required 0/1", wb_valid, in_ready);
        end
        tests_run++;
        if (psr !== 5'd0 || carry !== 1'b0 || wb_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: psr=%b carry=%0b wb_count=%h required 0", psr, carry, wb_count);
        end
        tests_run++;
        if (wb_data !== 16'd0 || wb_addr !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_head: wb_data=%h wb_addr=%h required 0", wb_data, wb_addr);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        in_valid = 1; reg_we = 1; flag_we = 1; wb_ready = 1;
        S = 16'h1234; dest = 4'd3; CLFZN = 5'b10010;
        tick();
        in_valid = 0; reg_we = 0; flag_we = 0;
        tests_run++;
        if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 16'h1234) begin
            tests_failed++;
            $display("[TB] FAIL single_head: valid=%0b addr=%h data=%h required 1/3/1234", wb_valid, wb_addr, wb_data);
        end
        tests_run++;
        if (psr !== 5'b10010 || carry !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_psr: psr=%b carry=%0b required 10010/1", psr, carry);
        end
        tick();
        tests_run++;
        if (wb_count !== 16'd1 || wb_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_retire: wb_count=%h wb_valid=%0b required 1/0", wb_count, wb_valid);
        end
        $display("[TB] single write 0x1234 -> r3 retired");
    endtask

    task automatic test_back_to_back();
        wb_ready = 0; in_valid = 1; reg_we = 1; flag_we = 0; dest = 4'd5;
        S = 16'h000A; tick();
        S = 16'h000B; tick();
        S = 16'h000C;
        tests_run++;
        if (in_ready !== 1'b0 || wb_data !== 16'h000A) begin
            tests_failed++;
            $display("[TB] FAIL b2b_full: in_ready=%0b head=%h required 0/000A", in_ready, wb_data);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || wb_data !== 16'h000A || wb_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold: in_ready=%0b head=%h valid=%0b required 0/000A/1", in_ready, wb_data, wb_valid);
        end
        wb_ready = 1;
        tick();
        tests_run++;
        if (wb_data !== 16'h000B || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: head=%h in_ready=%0b required 000B/1", wb_data, in_ready);
        end
        tick();
        in_valid = 0; reg_we = 0;
        tests_run++;
        if (wb_data !== 16'h000C || wb_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_third: head=%h valid=%0b required 000C/1", wb_data, wb_valid);
        end
        tick();
        tests_run++;
        if (wb_valid !== 1'b0 || wb_count !== m_cnt || m_cnt !== 16'd4) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain: valid=%0b wb_count=%h required 0/%h", wb_valid, wb_count, m_cnt);
        end
        $display("[TB] back-to-back A,B,C retired in order");
    endtask

    task automatic test_simul_push_retire();
        wb_ready = 0; in_valid = 1; reg_we = 1; flag_we = 0;
        S = 16'h5555; dest = 4'd1;
        tick();
        S = 16'h6666; dest = 4'd2; wb_ready = 1;
        tick();
        in_valid = 0; reg_we = 0; wb_ready = 0;
        tests_run++;
        if (wb_valid !== 1'b1 || in_ready !== 1'b1 || wb_data !== 16'h6666 || wb_addr !== 4'd2) begin
            tests_failed++;
            $display("[TB] FAIL simul: valid=%0b in_ready=%0b head=%h/%h required 1/1/6666/2", wb_valid, in_ready, wb_data, wb_addr);
        end
        wb_ready = 1;
        tick();
        wb_ready = 0;
        $display("[TB] simultaneous push+retire at count 1");
    endtask

    task automatic test_flags();
        in_valid = 1; reg_we = 0; flag_we = 1; CLFZN = 5'b00001; wb_ready = 1;
        tick();
        tests_run++;
        if (psr !== 5'b00001 || wb_valid !== 1'b0 || wb_count !== m_cnt) begin
            tests_failed++;
            $display("[TB] FAIL flags_only: psr=%b valid=%0b cnt=%h required 00001/0/%h", psr, wb_valid, wb_count, m_cnt);
        end
        reg_we = 1; flag_we = 0; CLFZN = 5'b11111; S = 16'hBEEF; dest = 4'd9; wb_ready = 0;
        tick();
        in_valid = 0; reg_we = 0;
        tests_run++;
        if (psr !== 5'b00001 || wb_valid !== 1'b1 || wb_data !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL flags_hold: psr=%b valid=%0b head=%h required 00001/1/BEEF", psr, wb_valid, wb_data);
        end
        wb_ready = 1;
        tick();
        wb_ready = 0;
        $display("[TB] flag-only and reg-only writes");
    endtask

    task automatic test_reset_mid();
        wb_ready = 0; in_valid = 1; reg_we = 1; flag_we = 1; CLFZN = 5'b10101;
        S = 16'h1111; dest = 4'd4; tick();
        S = 16'h2222; dest = 4'd6; tick();
        reset = 1; wb_ready = 1; S = 16'h3333;
        tick();
        reset = 0; in_valid = 0; reg_we = 0; flag_we = 0;
        tests_run++;
        if (wb_valid !== 1'b0 || psr !== 5'd0 || wb_count !== 16'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: valid=%0b psr=%b cnt=%h in_ready=%0b required 0/0/0/1", wb_valid, psr, wb_count, in_ready);
        end
        tick();
        tick();
        tests_run++;
        if (wb_valid !== 1'b0 || wb_data !== 16'd0 || wb_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_stale: valid=%0b data=%h cnt=%h required 0/0/0", wb_valid, wb_data, wb_count);
        end
        wb_ready = 0;
        $display("[TB] reset with 2 pending discarded");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            in_valid = $urandom_range(0, 1);
            reg_we   = $urandom_range(0, 3) != 0;
            flag_we  = $urandom_range(0, 1);
            wb_ready = $urandom_range(0, 2) != 0;
            S        = 16'($urandom);
            CLFZN    = 5'($urandom);
            dest     = 4'($urandom);
            tick();
            tests_run++;
            if (wb_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)
                || wb_data !== ((mq.size() != 0) ? mq[0].d : 16'h0)
                || wb_addr !== ((mq.size() != 0) ? mq[0].a : 4'h0)
                || psr !== m_psr || carry !== m_psr[4] || wb_count !== m_cnt) begin
                tests_failed++;
                errs++;
                $display("[TB] FAIL random[%0d]: valid=%0b rdy=%0b head=%h/%h psr=%b cnt=%h required depth=%0d psr=%b cnt=%h",
                         i, wb_valid, in_ready, wb_addr, wb_data, psr, wb_count, mq.size(), m_psr, m_cnt);
            end
        end
        reset = 0;
        idle_inputs();
        $display("[TB] random run: 400 cycles, %0d errors", errs);
    endtask

    task automatic test_wrap();
        int guard;
        reset = 1; idle_inputs(); tick(); reset = 0;
        in_valid = 1; reg_we = 1; wb_ready = 1; dest = 4'd7;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            S = 16'($urandom);
            tick();
            guard++;
        end
        in_valid = 0; reg_we = 0;
        tests_run++;
        if (wb_count !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL wrap_preload: wb_count=%h required FFFF (guard=%0d)", wb_count, guard);
        end
        tick();
        tests_run++;
        if (wb_count !== 16'h0000 || wb_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap: wb_count=%h valid=%0b required 0000/0", wb_count, wb_valid);
        end
        $display("[TB] wb_count wrap FFFF -> 0000");
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_simul_push_retire();
        test_flags();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
